// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bus for seq_divider
interface seq_divider_if #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
);
    logic            start;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            busy;
    logic            done;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per clock
module seq_divider #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = (DW_N > 1) ? $clog2(DW_N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [DW_N-1:0] shift_q;
    logic [DW_D-1:0] dvs_q;
    logic [DW_D-1:0] part_q;
    logic [CW-1:0]   cnt_q;
    logic [DW_N-1:0] quot_q;
    logic [DW_D-1:0] rem_q;
    logic            dbz_q;
    logic            done_q;

    logic            accept;
    logic            accept_zero;
    logic            last;
    logic [DW_D:0]   trial;
    logic            qbit;
    logic [DW_D-1:0] part_next;
    logic [DW_N-1:0] shift_next;

    // One restoring step: the trial value is one bit wider than the divisor so the compare cannot overflow;
    // when it fits, the difference is below the divisor and therefore fits back into DW_D bits.
    always_comb begin
        trial      = {part_q, shift_q[DW_N-1]};
        qbit       = (trial >= {1'b0, dvs_q});
        part_next  = qbit ? DW_D'(trial - {1'b0, dvs_q}) : trial[DW_D-1:0];
        shift_next = {shift_q[DW_N-2:0], qbit};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and step controls; a zero divisor completes at once without entering RUN.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        accept_zero = 1'b0;
        last        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        accept_zero = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers; results only move on completion edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_q <= bus.dividend;
                dvs_q   <= bus.divisor;
                part_q  <= '0;
                cnt_q   <= CW'(DW_N - 1);
            end
            if (accept_zero) begin
                quot_q <= '1;
                rem_q  <= '0;
                dbz_q  <= 1'b1;
                done_q <= 1'b1;
            end
            if (state == RUN) begin
                shift_q <= shift_next;
                part_q  <= part_next;
                cnt_q   <= cnt_q - CW'(1);
                if (last) begin
                    quot_q <= shift_next;
                    rem_q  <= part_next;
                    dbz_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and random checks of seq_divider
module tb_seq_divider;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    seq_divider_if #(.DW_N(16), .DW_D(8)) bus ();

    seq_divider #(.DW_N(16), .DW_D(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives start now (caller keeps away from the edge), then follows the run until done.
    // poke_at >= 0 pulses a second start with 50/3 for one edge during the run.
    task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int poke_at,
                          output int lat, output int busy_cnt, output int done_cnt);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'h5A5A;
        bus.divisor  = 8'h33;
        lat      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        done_cnt = bus.done ? 1 : 0;
        while (!bus.done && lat < 40) begin
            if (lat == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = 16'd50;
                bus.divisor  = 8'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
        end
        if (lat >= 40) check("done_timeout", 32'(lat), 32'd16);
    endtask

    task automatic expect_result(input string tag, input logic [15:0] q, input logic [7:0] r, input logic z);
        check({tag, "_q"}, 32'(bus.quotient), 32'(q));
        check({tag, "_r"}, 32'(bus.remainder), 32'(r));
        check({tag, "_dbz"}, 32'(bus.dbz), 32'(z));
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        logic [15:0] a;
        logic [7:0]  b;

        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        expect_result("rst", 16'd0, 8'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // 1: 1000/7
        @(negedge clk);
        do_div(16'd1000, 8'd7, -1, lat, busy_cnt, done_cnt);
        check("t1_lat", 32'(lat), 16);
        check("t1_busy_cycles", 32'(busy_cnt), 16);
        check("t1_busy_at_done", 32'(bus.busy), 0);
        expect_result("t1", 16'd142, 8'd6, 1'b0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", 32'(bus.done), 0);
        expect_result("t1_hold", 16'd142, 8'd6, 1'b0);

        // 2: boundaries
        @(negedge clk);
        do_div(16'd65535, 8'd255, -1, lat, busy_cnt, done_cnt);
        expect_result("t2a", 16'd257, 8'd0, 1'b0);
        @(negedge clk);
        do_div(16'd100, 8'd200, -1, lat, busy_cnt, done_cnt);
        expect_result("t2b", 16'd0, 8'd100, 1'b0);
        @(negedge clk);
        do_div(16'd255, 8'd1, -1, lat, busy_cnt, done_cnt);
        expect_result("t2c", 16'd255, 8'd0, 1'b0);

        // 3: divide by zero
        @(negedge clk);
        do_div(16'd1234, 8'd0, -1, lat, busy_cnt, done_cnt);
        check("t3_lat", 32'(lat), 0);
        check("t3_busy_cycles", 32'(busy_cnt), 0);
        expect_result("t3", 16'hFFFF, 8'd0, 1'b1);
        @(posedge clk);
        #1;
        check("t3_done_pulse", 32'(bus.done), 0);

        // 4: start while busy is ignored
        @(negedge clk);
        do_div(16'd1000, 8'd7, 4, lat, busy_cnt, done_cnt);
        check("t4_lat", 32'(lat), 16);
        check("t4_done_cnt", 32'(done_cnt), 1);
        expect_result("t4", 16'd142, 8'd6, 1'b0);
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        check("t4_no_extra", 32'(done_cnt), 0);

        // 5: reset mid-run
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd40000;
        bus.divisor  = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        expect_result("t5", 16'd0, 8'd0, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        done_cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        check("t5_no_done", 32'(done_cnt), 0);

        // 6: back-to-back, second start during done
        @(negedge clk);
        do_div(16'd1000, 8'd7, -1, lat, busy_cnt, done_cnt);
        expect_result("t6a", 16'd142, 8'd6, 1'b0);
        do_div(16'd500, 8'd9, -1, lat, busy_cnt, done_cnt);
        check("t6_lat", 32'(lat), 16);
        expect_result("t6b", 16'd55, 8'd5, 1'b0);

        // Random operands against a reference model
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom);
            case (i % 8)
                0: b = 8'd0;
                1: b = 8'd1;
                2: begin b = 8'($urandom_range(255, 2)); a = 16'($urandom_range(int'(b) - 1, 0)); end
                default: b = 8'($urandom);
            endcase
            @(negedge clk);
            do_div(a, b, -1, lat, busy_cnt, done_cnt);
            if (b == 8'd0) begin
                expect_result("rnd_dbz", 16'hFFFF, 8'd0, 1'b1);
            end else begin
                expect_result("rnd", a / 16'(b), 8'(a % 16'(b)), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
